ofdm_tx_frame_sched: RTL and testbench
======================================

OFDM_TX_FRAME_SCHED -- requirements
Module: ofdm_tx_frame_sched

Interface
REQ-001 SHALL have parameter DAT_PER_SYM, default 1440, data words per OFDM symbol.
REQ-002 SHALL have parameter PRE_SYMS, default 1, preamble symbols per frame (>=1).
REQ-003 SHALL have parameter PAY_SYMS, default 26, payload symbols per frame (>=1, <=255).
REQ-004 SHALL have parameter GAP_CYC, default 4, idle cycles after each frame (>=1).
REQ-005 SHALL have port CLK_I, in, 1, sole clock, rising edge.
REQ-006 SHALL have port RST_I, in, 1, asynchronous active-low reset.
REQ-007 SHALL have port EN_I, in, 1, frame start enable.
REQ-008 SHALL have ports A_DAT_I in 6, A_CYC_I/A_STB_I/A_WE_I in 1 each, A_ACK_O out 1: preamble source bus.
REQ-009 SHALL have ports B_DAT_I in 6, B_CYC_I/B_STB_I/B_WE_I in 1 each, B_ACK_O out 1: payload source bus.
REQ-010 SHALL have ports DAT_O out 6, CYC_O/STB_O/WE_O out 1 each, ACK_I in 1: bus to QAM64 modulator.
REQ-011 SHALL have port SYM_IDX_O, out, 8, index of current symbol in frame.
REQ-012 SHALL have ports FRM_START_O, FRM_DONE_O, ERR_O, out, 1 each, single-cycle status pulses.

Function
REQ-013 SHALL implement FSM states IDLE, PRE, PAY, GAP.
REQ-014 SHALL transition IDLE->PRE when EN_I=1 and A_CYC_I=1 in the same cycle, and pulse FRM_START_O on that cycle.
REQ-015 SHALL, in PRE, route A to the output: DAT_O=A_DAT_I, STB_O=A_STB_I&A_WE_I, A_ACK_O=ACK_I&STB_O, B_ACK_O=0.
REQ-016 SHALL, in PAY, route B likewise, with A_ACK_O=0.
REQ-017 SHALL drive all routing combinationally (zero-cycle latency source-to-modulator and ACK back).
REQ-018 SHALL assert CYC_O=WE_O=1 throughout PRE and PAY, and 0 in IDLE and GAP; STB_O and both ACKs SHALL be 0 in IDLE and GAP.
REQ-019 SHALL count one word per cycle with STB_O=1 and ACK_I=1; word counter (11 bits) SHALL wrap DAT_PER_SYM-1->0 and increment SYM_IDX_O on wrap.
REQ-020 SHALL move PRE->PAY on the wrap completing symbol PRE_SYMS-1, with SYM_IDX_O continuing (not resetting) into payload.
REQ-021 SHALL move PAY->GAP on the wrap completing symbol PRE_SYMS+PAY_SYMS-1, pulsing FRM_DONE_O that cycle.
REQ-022 SHALL hold GAP for exactly GAP_CYC cycles, then enter IDLE with SYM_IDX_O and word counter cleared.
REQ-023 SHALL abort to GAP, pulsing ERR_O (not FRM_DONE_O), if the active source drops CYC_I while in PRE or PAY; a word acked in that same cycle SHALL NOT be counted.
REQ-024 SHALL ignore EN_I outside IDLE; deasserting EN_I mid-frame SHALL NOT shorten the frame.
REQ-025 SHALL leave counters unchanged on stall cycles (STB_O=1, ACK_I=0 or STB_O=0).
REQ-026 SHALL, when PRE_SYMS+PAY_SYMS exceeds 255, be rejected at elaboration.

Reset
REQ-027 SHALL, on RST_I=0, asynchronously force state IDLE, counters 0, SYM_IDX_O=0, all pulses 0, CYC_O/STB_O/WE_O/ACK outputs 0.
REQ-028 SHALL, on reset mid-frame, discard the frame without ERR_O, and SHALL restart only via REQ-014 after RST_I=1.

Structure
REQ-029 SHALL place state encoding and default DAT_PER_SYM/PRE_SYMS/PAY_SYMS/GAP_CYC constants in shared package ofdm_tx_pkg.
REQ-030 SHALL implement word/symbol counting in one sub-module, sym_counter, with inputs inc, clr and outputs word count, symbol index, wrap.
REQ-031 SHALL sit between the upstream sources and the QAM64 modulator input of the 802.22 TX chain, without changing the modulator interface.

Verification (DAT_PER_SYM=4, PRE_SYMS=1, PAY_SYMS=2, GAP_CYC=3 unless stated)
REQ-032 SHALL verify nominal frame: EN_I=1, A and B always valid, ACK_I=1 -> 4 A words then 8 B words on DAT_O, CYC_O high 12 cycles, FRM_DONE_O on 12th, CYC_O low 3 cycles.
REQ-033 SHALL verify backpressure: ACK_I toggling 1/0 -> same 12 words in order, no duplicates or drops, CYC_O high 24 cycles.
REQ-034 SHALL verify abort: B_CYC_I=0 after 5 payload words -> ERR_O pulse, no FRM_DONE_O, GAP 3 cycles, SYM_IDX_O=0 in IDLE.
REQ-035 SHALL verify reset mid-PAY: RST_I=0 after 2 payload words -> all outputs 0 immediately, no ERR_O, next frame starts at SYM_IDX_O=0.
REQ-036 SHALL verify EN_I gating: EN_I=0 with A_CYC_I=1 -> stays IDLE, A_ACK_O=0; EN_I dropped mid-PRE -> full 12-word frame completes.
REQ-037 SHALL verify defaults: 1440x27 words -> SYM_IDX_O reaches 26, single FRM_DONE_O.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM TX frame scheduler: state encoding,
// default frame geometry and counter widths.
package ofdm_tx_pkg;

  localparam int DEF_DAT_PER_SYM = 1440;
  localparam int DEF_PRE_SYMS    = 1;
  localparam int DEF_PAY_SYMS    = 26;
  localparam int DEF_GAP_CYC     = 4;

  localparam int WORD_W = 11;
  localparam int SYM_W  = 8;
  localparam int DATA_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_PAY  = 2'd2,
    ST_GAP  = 2'd3
  } frame_state_e;

endpackage

// File: rtl/sym_counter.sv
// Word-within-symbol and symbol-within-frame counter; wrap strobes on the
// accepted word that completes a symbol.
module sym_counter
  import ofdm_tx_pkg::*;
#(
  parameter int DAT_PER_SYM = DEF_DAT_PER_SYM
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [WORD_W-1:0] word_o,
  output logic [SYM_W-1:0]  sym_o,
  output logic              wrap_o
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DAT_PER_SYM - 1);

  logic [WORD_W-1:0] word_q, word_d;
  logic [SYM_W-1:0]  sym_q, sym_d;

  assign wrap_o = inc_i && (word_q == LAST_WORD);
  assign word_o = word_q;
  assign sym_o  = sym_q;

  // Clear wins over increment so a frame-ending wrap leaves both counters at zero.
  always_comb begin
    word_d = word_q;
    sym_d  = sym_q;
    if (clr_i) begin
      word_d = '0;
      sym_d  = '0;
    end else if (inc_i) begin
      if (wrap_o) begin
        word_d = '0;
        sym_d  = sym_q + SYM_W'(1);
      end else begin
        word_d = word_q + WORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      sym_q  <= '0;
    end else begin
      word_q <= word_d;
      sym_q  <= sym_d;
    end
  end

endmodule

// File: rtl/ofdm_tx_frame_sched.sv
// Frame scheduler ahead of the QAM64 modulator: muxes the preamble source
// then the payload source onto the modulator bus and frames them with a gap.
module ofdm_tx_frame_sched
  import ofdm_tx_pkg::*;
#(
  parameter int DAT_PER_SYM = DEF_DAT_PER_SYM,
  parameter int PRE_SYMS    = DEF_PRE_SYMS,
  parameter int PAY_SYMS    = DEF_PAY_SYMS,
  parameter int GAP_CYC     = DEF_GAP_CYC
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              EN_I,
  input  logic [DATA_W-1:0] A_DAT_I,
  input  logic              A_CYC_I,
  input  logic              A_STB_I,
  input  logic              A_WE_I,
  output logic              A_ACK_O,
  input  logic [DATA_W-1:0] B_DAT_I,
  input  logic              B_CYC_I,
  input  logic              B_STB_I,
  input  logic              B_WE_I,
  output logic              B_ACK_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  input  logic              ACK_I,
  output logic [SYM_W-1:0]  SYM_IDX_O,
  output logic              FRM_START_O,
  output logic              FRM_DONE_O,
  output logic              ERR_O
);

  if (PRE_SYMS < 1 || PAY_SYMS < 1 || GAP_CYC < 1 || PRE_SYMS + PAY_SYMS > 255 ||
      DAT_PER_SYM < 1 || DAT_PER_SYM > 2048) begin : g_bad_params
    $error("ofdm_tx_frame_sched: illegal frame geometry parameters");
  end

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [SYM_W-1:0] LAST_PRE_SYM = SYM_W'(PRE_SYMS - 1);
  localparam logic [SYM_W-1:0] LAST_PAY_SYM = SYM_W'(PRE_SYMS + PAY_SYMS - 1);
  localparam logic [GAP_W-1:0] LAST_GAP     = GAP_W'(GAP_CYC - 1);

  frame_state_e      state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              in_pre, in_pay, src_cyc, src_stb, fire;
  logic              cnt_inc, cnt_clr, cnt_wrap;
  logic [SYM_W-1:0]  sym_idx;
  logic [WORD_W-1:0] word_cnt_unused;

  assign in_pre  = (state_q == ST_PRE);
  assign in_pay  = (state_q == ST_PAY);
  assign src_cyc = (in_pre & A_CYC_I) | (in_pay & B_CYC_I);
  assign src_stb = (in_pre & A_STB_I & A_WE_I) | (in_pay & B_STB_I & B_WE_I);
  assign fire    = src_stb & ACK_I;
  // A word accepted while its source is dropping the cycle belongs to the aborted frame.
  assign cnt_inc = fire & src_cyc;

  assign DAT_O     = in_pre ? A_DAT_I : (in_pay ? B_DAT_I : '0);
  assign CYC_O     = in_pre | in_pay;
  assign WE_O      = in_pre | in_pay;
  assign STB_O     = src_stb;
  assign A_ACK_O   = in_pre & fire;
  assign B_ACK_O   = in_pay & fire;
  assign SYM_IDX_O = sym_idx;

  sym_counter #(
    .DAT_PER_SYM (DAT_PER_SYM)
  ) u_sym_counter (
    .clk_i  (CLK_I),
    .rst_ni (RST_I),
    .inc_i  (cnt_inc),
    .clr_i  (cnt_clr),
    .word_o (word_cnt_unused),
    .sym_o  (sym_idx),
    .wrap_o (cnt_wrap)
  );

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    cnt_clr     = 1'b0;
    FRM_START_O = 1'b0;
    FRM_DONE_O  = 1'b0;
    ERR_O       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (RST_I && EN_I && A_CYC_I) begin
          state_d     = ST_PRE;
          FRM_START_O = 1'b1;
        end
      end
      ST_PRE: begin
        if (!A_CYC_I) begin
          state_d = ST_GAP;
          ERR_O   = 1'b1;
        end else if (cnt_wrap && sym_idx == LAST_PRE_SYM) begin
          state_d = ST_PAY;
        end
      end
      ST_PAY: begin
        if (!B_CYC_I) begin
          state_d = ST_GAP;
          ERR_O   = 1'b1;
        end else if (cnt_wrap && sym_idx == LAST_PAY_SYM) begin
          state_d    = ST_GAP;
          FRM_DONE_O = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == LAST_GAP) begin
          state_d = ST_IDLE;
          gap_d   = '0;
          cnt_clr = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_ofdm_tx_frame_sched.sv
// Randomized and directed bench for ofdm_tx_frame_sched against a word-count
// reference model; a second instance exercises the default frame geometry.
module tb_ofdm_tx_frame_sched;

  localparam int DPS       = 4;
  localparam int PRE_S     = 1;
  localparam int PAY_S     = 2;
  localparam int GAP_C     = 3;
  localparam int PRE_WORDS = DPS * PRE_S;
  localparam int TOT_WORDS = DPS * (PRE_S + PAY_S);
  localparam int DEF_WORDS = 1440 * 27;

  localparam int M_IDLE = 0;
  localparam int M_PRE  = 1;
  localparam int M_PAY  = 2;
  localparam int M_GAP  = 3;

  logic       clk  = 1'b0;
  logic       rstN = 1'b0;
  logic       en = 1'b0, aCyc = 1'b0, aStb = 1'b0, aWe = 1'b0;
  logic       bCyc = 1'b0, bStb = 1'b0, bWe = 1'b0, ack = 1'b0;
  logic [5:0] aDat = 6'h0, bDat = 6'h0;
  logic [5:0] datO;
  logic       cycO, stbO, weO, aAckO, bAckO, startO, doneO, errO;
  logic [7:0] symO;

  logic       d2En = 1'b0;
  logic [5:0] d2Dat;
  logic       d2Cyc, d2Stb, d2We, d2AAck, d2BAck, d2Start, d2Done, d2Err;
  logic [7:0] d2Sym;

  int checks = 0, failures = 0;
  int mState = M_IDLE, wordsDone = 0, gapLeft = 0;
  logic [5:0] aWord = 6'h0, bWord = 6'h0;
  int tick, cycHigh, accCnt, startCnt, doneCnt, errCnt;
  int lastStart, lastDone, lastErr, doneAtHigh, accAtDone;
  int d2High = 0, d2Acc = 0, d2Bad = 0, d2MaxSym = 0, d2Starts = 0, d2Dones = 0, d2Errs = 0;

  always #5 clk = ~clk;

  ofdm_tx_frame_sched #(
    .DAT_PER_SYM (DPS), .PRE_SYMS (PRE_S), .PAY_SYMS (PAY_S), .GAP_CYC (GAP_C)
  ) dut (
    .CLK_I (clk), .RST_I (rstN), .EN_I (en),
    .A_DAT_I (aDat), .A_CYC_I (aCyc), .A_STB_I (aStb), .A_WE_I (aWe), .A_ACK_O (aAckO),
    .B_DAT_I (bDat), .B_CYC_I (bCyc), .B_STB_I (bStb), .B_WE_I (bWe), .B_ACK_O (bAckO),
    .DAT_O (datO), .CYC_O (cycO), .STB_O (stbO), .WE_O (weO), .ACK_I (ack),
    .SYM_IDX_O (symO), .FRM_START_O (startO), .FRM_DONE_O (doneO), .ERR_O (errO)
  );

  ofdm_tx_frame_sched dutDefault (
    .CLK_I (clk), .RST_I (rstN), .EN_I (d2En),
    .A_DAT_I (6'h15), .A_CYC_I (1'b1), .A_STB_I (1'b1), .A_WE_I (1'b1), .A_ACK_O (d2AAck),
    .B_DAT_I (6'h2A), .B_CYC_I (1'b1), .B_STB_I (1'b1), .B_WE_I (1'b1), .B_ACK_O (d2BAck),
    .DAT_O (d2Dat), .CYC_O (d2Cyc), .STB_O (d2Stb), .WE_O (d2We), .ACK_I (1'b1),
    .SYM_IDX_O (d2Sym), .FRM_START_O (d2Start), .FRM_DONE_O (d2Done), .ERR_O (d2Err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic clearStats();
    tick = 0; cycHigh = 0; accCnt = 0; startCnt = 0; doneCnt = 0; errCnt = 0;
    lastStart = 0; lastDone = 0; lastErr = 0; doneAtHigh = 0; accAtDone = 0;
  endtask

  // Expected outputs follow from the frame position measured in accepted words.
  task automatic evalCycle();
    logic eCyc, eStb, eAAck, eBAck, eStart, eDone, eErr, fire, srcCyc;
    logic [5:0] eDat;
    int eSym;
    eCyc = 1'b0; eStb = 1'b0; eAAck = 1'b0; eBAck = 1'b0;
    eStart = 1'b0; eDone = 1'b0; eErr = 1'b0; fire = 1'b0; srcCyc = 1'b0;
    eDat = 6'h0; eSym = 0;
    if (!rstN) begin
      mState = M_IDLE;
      wordsDone = 0;
    end else if (mState == M_IDLE) begin
      eStart = en && aCyc;
    end else if (mState == M_PRE || mState == M_PAY) begin
      eCyc   = 1'b1;
      srcCyc = (mState == M_PRE) ? aCyc : bCyc;
      eStb   = (mState == M_PRE) ? (aStb && aWe) : (bStb && bWe);
      eDat   = (mState == M_PRE) ? aDat : bDat;
      fire   = eStb && ack;
      eAAck  = (mState == M_PRE) && fire;
      eBAck  = (mState == M_PAY) && fire;
      eErr   = !srcCyc;
      eDone  = (mState == M_PAY) && srcCyc && fire && (wordsDone + 1 == TOT_WORDS);
      eSym   = wordsDone / DPS;
    end
    checkOutput("cyc", 32'(cycO), 32'(eCyc));
    checkOutput("we", 32'(weO), 32'(eCyc));
    checkOutput("stb", 32'(stbO), 32'(eStb));
    checkOutput("aAck", 32'(aAckO), 32'(eAAck));
    checkOutput("bAck", 32'(bAckO), 32'(eBAck));
    checkOutput("frmStart", 32'(startO), 32'(eStart));
    checkOutput("frmDone", 32'(doneO), 32'(eDone));
    checkOutput("err", 32'(errO), 32'(eErr));
    if (mState != M_GAP) checkOutput("symIdx", 32'(symO), eSym);
    if (eCyc) checkOutput("dat", 32'(datO), 32'(eDat));

    tick++;
    if (cycO) cycHigh++;
    if (cycO && stbO && ack) accCnt++;
    if (startO) begin startCnt++; lastStart = tick; end
    if (errO) begin errCnt++; lastErr = tick; end
    if (doneO) begin doneCnt++; lastDone = tick; doneAtHigh = cycHigh; accAtDone = accCnt; end

    if (rstN) begin
      if (mState == M_IDLE) begin
        if (en && aCyc) begin mState = M_PRE; wordsDone = 0; end
      end else if (mState == M_PRE || mState == M_PAY) begin
        if (eAAck) aWord = 6'($urandom);
        if (eBAck) bWord = 6'($urandom);
        if (!srcCyc) begin
          mState = M_GAP; gapLeft = GAP_C;
        end else if (fire) begin
          wordsDone++;
          if (mState == M_PRE && wordsDone == PRE_WORDS) mState = M_PAY;
          else if (mState == M_PAY && wordsDone == TOT_WORDS) begin mState = M_GAP; gapLeft = GAP_C; end
        end
      end else begin
        gapLeft--;
        if (gapLeft == 0) mState = M_IDLE;
      end
    end
  endtask

  task automatic applyStimulus(input logic en_, input logic aCyc_, input logic aStb_, input logic aWe_,
                               input logic bCyc_, input logic bStb_, input logic bWe_, input logic ack_);
    en = en_; aCyc = aCyc_; aStb = aStb_; aWe = aWe_;
    bCyc = bCyc_; bStb = bStb_; bWe = bWe_; ack = ack_;
    aDat = aWord; bDat = bWord;
    #2;
    evalCycle();
    @(negedge clk);
  endtask

  task automatic drainToIdle();
    for (int i = 0; i < 60 && mState != M_IDLE; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic sampleDefault();
    #2;
    if (d2Cyc) d2High++;
    if (d2AAck || d2BAck) d2Acc++;
    if (d2Cyc && !(d2Stb && d2We)) d2Bad++;
    if (d2BAck && d2Dat != 6'h2A) d2Bad++;
    if (int'(d2Sym) > d2MaxSym) d2MaxSym = int'(d2Sym);
    if (d2Start) d2Starts++;
    if (d2Done) d2Dones++;
    if (d2Err) d2Errs++;
    @(negedge clk);
  endtask

  initial begin
    aWord = 6'($urandom);
    bWord = 6'($urandom);
    clearStats();
    @(negedge clk);

    $display("[TB] reset holds outputs low");
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    rstN = 1'b1;

    $display("[TB] EN gating");
    clearStats();
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("gateNoStart", startCnt, 0);
    checkOutput("gateNoWords", accCnt, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (30) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("enDropWords", accCnt, TOT_WORDS);
    checkOutput("enDropDone", doneCnt, 1);

    $display("[TB] nominal frame");
    clearStats();
    for (int i = 0; i < 40 && !(doneCnt >= 1 && startCnt >= 2); i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("nomCycHigh", doneAtHigh, 12);
    checkOutput("nomWords", accAtDone, 12);
    checkOutput("nomGapToStart", lastStart - lastDone, GAP_C + 1);
    checkOutput("nomDoneCount", doneCnt, 1);
    drainToIdle();

    $display("[TB] backpressure");
    clearStats();
    for (int i = 0; i < 60 && doneCnt == 0; i++)
      applyStimulus(i == 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, (i % 2) == 0);
    checkOutput("bpCycHigh", doneAtHigh, 24);
    checkOutput("bpWords", accAtDone, 12);
    checkOutput("bpDoneCount", doneCnt, 1);
    drainToIdle();

    $display("[TB] payload abort");
    clearStats();
    for (int i = 0; i < 40 && mState != M_GAP; i++)
      applyStimulus(i == 0, 1'b1, 1'b1, 1'b1, !(mState == M_PAY && wordsDone == PRE_WORDS + 5),
                    1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 10 && startCnt < 2; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("abortErr", errCnt, 1);
    checkOutput("abortNoDone", doneCnt, 0);
    checkOutput("abortGapToStart", lastStart - lastErr, GAP_C + 1);
    drainToIdle();

    $display("[TB] reset mid payload");
    clearStats();
    for (int i = 0; i < 40 && !(mState == M_PAY && wordsDone == PRE_WORDS + 2); i++)
      applyStimulus(i == 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstCyc", 32'(cycO), 0);
    checkOutput("rstStb", 32'(stbO), 0);
    checkOutput("rstWe", 32'(weO), 0);
    checkOutput("rstAAck", 32'(aAckO), 0);
    checkOutput("rstBAck", 32'(bAckO), 0);
    checkOutput("rstSym", 32'(symO), 0);
    checkOutput("rstErr", 32'(errO), 0);
    mState = M_IDLE;
    wordsDone = 0;
    @(negedge clk);
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rstNoErr", errCnt, 0);
    rstN = 1'b1;
    clearStats();
    for (int i = 0; i < 40 && doneCnt == 0; i++)
      applyStimulus(i == 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rstRestartWords", accAtDone, 12);
    checkOutput("rstRestartDone", doneCnt, 1);
    drainToIdle();

    $display("[TB] random traffic");
    clearStats();
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 63) != 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0);
    checkOutput("rndProgress", 32'(doneCnt > 0), 1);

    $display("[TB] default geometry frame");
    d2En = 1'b1;
    for (int i = 0; i < DEF_WORDS + 40 && d2Dones == 0; i++) sampleDefault();
    repeat (2) sampleDefault();
    checkOutput("defMaxSym", d2MaxSym, 26);
    checkOutput("defDone", d2Dones, 1);
    checkOutput("defStart", d2Starts, 1);
    checkOutput("defErr", d2Errs, 0);
    checkOutput("defCycHigh", d2High, DEF_WORDS);
    checkOutput("defWords", d2Acc, DEF_WORDS);
    checkOutput("defBusShape", d2Bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
